// File: rtl/countdown_display_pkg.sv
// countdown_display_pkg: segment codes, digit count and alert states for countdown_display
package countdown_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic [1:0] {NORMAL, ALERT, DONE} alert_state_t;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/countdown_display_seg7_decoder.sv
// seg7_decoder: digit + blank + dp to {dp,g,f,e,d,c,b,a}, combinational
module seg7_decoder
  import countdown_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = {dp, blank ? SEG_BLANK : seg7(digit)};
endmodule

// File: rtl/countdown_display.sv
// countdown_display: 4-digit multiplexed readout of the countdown value with pause dp and expiry blink.
// Blink alert FSM is compiled in only when COUNTDOWN_BLINK_EN is defined.
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int BLINK_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_time_val,
  input  logic       i_timeout,
  input  logic       i_en,
  input  logic       i_start_timer,
  output logic [3:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_alert
);
  localparam int SCAN_DIV = CLK_FREQ / (SCAN_HZ * NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV + 1);
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [3:0] val_l, ones, dig;
  logic en_l, tick, frame, tens, blank, dp, blank_ph, dp_ok;
  logic [7:0] seg_d;
  assign tick = presc == PW'(SCAN_DIV - 1);
  assign frame = tick && idx == 2'd3;
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx <= '0;
      val_l <= '0;
      en_l <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      idx <= idx + 2'(tick);
      if (frame) begin
        val_l <= i_time_val;
        en_l <= i_en;
      end
    end
  end
  assign tens = val_l >= 4'd10;
  assign ones = tens ? val_l - 4'd10 : val_l;
  assign dig = idx[0] ? {3'b000, tens} : ones;
  assign blank = idx[1] | (idx[0] & ~tens) | blank_ph;
  assign dp = idx == 2'd0 && dp_ok;
  seg7_decoder u_dec (.digit(dig), .blank(blank), .dp(dp), .seg(seg_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      o_an <= '0;
      o_seg <= '0;
    end else begin
      o_an <= 4'b0001 << idx;
      o_seg <= blank_ph ? 8'h00 : seg_d;
    end
  end
`ifdef COUNTDOWN_BLINK_EN
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int DUR = BLINK_SECS * CLK_FREQ;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int DW = $clog2(DUR + 1);
  alert_state_t state, state_nx;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] dcnt;
  logic phase, enter, btog, dur_end;
  assign enter = i_timeout && !i_start_timer && state != ALERT;
  assign btog = bcnt == BW'(BLINK_DIV - 1);
  assign dur_end = dcnt == DW'(DUR - 1);
  always_ff @(posedge clk) state <= rst ? NORMAL : state_nx;
  always_comb state_nx = i_start_timer ? NORMAL : enter ? ALERT : (state == ALERT && dur_end) ? DONE : state;
  always_ff @(posedge clk) begin
    if (rst || i_start_timer || enter) begin
      bcnt <= '0;
      dcnt <= '0;
      phase <= 1'b1;
    end else if (state == ALERT) begin
      bcnt <= btog ? '0 : bcnt + 1'b1;
      phase <= phase ^ btog;
      dcnt <= dcnt + 1'b1;
    end
  end
  always_comb begin
    o_alert = state == ALERT;
    blank_ph = o_alert && !phase;
    dp_ok = !en_l && !o_alert;
  end
`else
  localparam int unused_cfg = BLINK_HZ + BLINK_SECS;
  logic unused_timeout;
  assign unused_timeout = i_timeout ^ i_start_timer;
  always_comb begin
    o_alert = 1'b0;
    blank_ph = 1'b0;
    dp_ok = !en_l;
  end
`endif
endmodule

// File: tb/tb_countdown_display.sv
// tb_countdown_display: vector table, corner sequences and random traffic against a cycle-count model
module tb_countdown_display;
  localparam int CF = 1000, SH = 50, BH = 5, BS = 2;
  localparam int SD = CF / (SH * 4), FR = SD * 4, BD = CF / (2 * BH), DUR = BS * CF;
`ifdef COUNTDOWN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  typedef struct {
    logic [3:0] v;
    logic       en;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] i_time_val = 4'd7;
  logic i_timeout = 1'b0, i_en = 1'b1, i_start_timer = 1'b0;
  logic [3:0] o_an;
  logic [7:0] o_seg;
  logic o_alert;
  int total = 0, bad = 0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  vec_t vecs [7];
  countdown_display #(.CLK_FREQ(CF), .SCAN_HZ(SH), .BLINK_HZ(BH), .BLINK_SECS(BS)) dut (
    .clk(clk), .rst(rst), .i_time_val(i_time_val), .i_timeout(i_timeout), .i_en(i_en),
    .i_start_timer(i_start_timer), .o_an(o_an), .o_seg(o_seg), .o_alert(o_alert)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: everything derived from the number of edges since reset and the alert entry time.
  int n = 0, a_t0 = 0;
  bit a_act = 0, armed = 0;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic e_alert;
  int m_val = 0;
  bit m_en = 1;
  function automatic bit in_alert(input int x);
    return a_act && (x - a_t0 - 1) < DUR;
  endfunction
  function automatic logic [7:0] ref_seg(input int d, input int v, input bit en, input bit al, input bit ph);
    if (al && !ph) return 8'h00;
    if (d == 0) return {!en && !al, segtab[v % 10]};
    if (d == 1 && v >= 10) return {1'b0, segtab[v / 10]};
    return 8'h00;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_val = 0; m_en = 1; a_act = 0;
      e_an = 4'h0; e_seg = 8'h00; e_alert = 1'b0;
    end else begin
      bit al, ph;
      int d;
      d = (n / SD) % 4;
      al = in_alert(n);
      ph = ((n - a_t0 - 1) / BD) % 2 == 0;
      e_an = 4'(1 << d);
      e_seg = ref_seg(d, m_val, m_en, al, ph);
      if (n % FR == FR - 1) begin m_val = int'(i_time_val); m_en = i_en; end
      if (i_start_timer) a_act = 0;
      else if (BLINK && i_timeout && !al) begin a_act = 1; a_t0 = n; end
      n++;
      e_alert = in_alert(n);
    end
    armed = 1;
  end
  always @(negedge clk) if (armed) begin
    check("model_an", int'(o_an), int'(e_an));
    check("model_seg", int'(o_seg), int'(e_seg));
    check("model_alert", int'(o_alert), int'(e_alert));
  end
  task automatic wait_an(input logic [3:0] t);
    int k = 0;
    while (o_an !== t && k < 100) begin @(negedge clk); k++; end
    check("wait_an", int'(o_an), int'(t));
  endtask
  task automatic fresh_d0;
    wait_an(4'b0010);
    wait_an(4'b0001);
  endtask
  task automatic pulse(input bit to, input bit st);
    i_timeout = to; i_start_timer = st;
    @(negedge clk);
    i_timeout = 0; i_start_timer = 0;
  endtask
  initial begin
    int k;
    vecs = '{'{4'd7, 1'b1, 8'h07, 8'h00}, '{4'd12, 1'b1, 8'h5B, 8'h06}, '{4'd5, 1'b0, 8'hED, 8'h00},
             '{4'd5, 1'b1, 8'h6D, 8'h00}, '{4'd15, 1'b1, 8'h6D, 8'h06}, '{4'd10, 1'b0, 8'hBF, 8'h06},
             '{4'd0, 1'b1, 8'h3F, 8'h00}};
    repeat (3) @(negedge clk);
    check("rst_an", int'(o_an), 0);
    check("rst_seg", int'(o_seg), 0);
    check("rst_alert", int'(o_alert), 0);
    rst = 0;
    foreach (vecs[i]) begin
      i_time_val = vecs[i].v; i_en = vecs[i].en;
      repeat (FR + 5) @(negedge clk);
      wait_an(4'b0001); check("vec_d0", int'(o_seg), int'(vecs[i].d0));
      wait_an(4'b0010); check("vec_d1", int'(o_seg), int'(vecs[i].d1));
      wait_an(4'b0100); check("vec_d2", int'(o_seg), 0);
      wait_an(4'b1000); check("vec_d3", int'(o_seg), 0);
    end
    i_time_val = 9;
    repeat (FR + 5) @(negedge clk);
    fresh_d0;
    check("mid_d0_9", int'(o_seg), 8'h6F);
    i_time_val = 8;
    repeat (SD - 1) begin @(negedge clk); check("mid_hold", int'(o_seg), 8'h6F); end
    fresh_d0;
    check("mid_d0_8", int'(o_seg), 8'h7F);
    i_time_val = 0;
    repeat (FR + 5) @(negedge clk);
    pulse(1, 0);
    check("alert_rise", int'(o_alert), int'(BLINK));
    k = 0;
    while (o_alert && k < DUR + 100) begin @(negedge clk); k++; end
    check("alert_len", k, BLINK ? DUR : 0);
    fresh_d0;
    check("done_d0", int'(o_seg), 8'h3F);
    pulse(1, 1);
    check("start_wins", int'(o_alert), 0);
    repeat (10) @(negedge clk);
    pulse(1, 0);
    check("alert_re", int'(o_alert), int'(BLINK));
    repeat (150) @(negedge clk);
    pulse(0, 1);
    check("alert_clr", int'(o_alert), 0);
    repeat (300) @(negedge clk);
    fresh_d0;
    check("clr_d0", int'(o_seg), 8'h3F);
    repeat (6000) begin
      @(negedge clk);
      rst = $urandom_range(0, 1999) == 0;
      if ($urandom_range(0, 29) == 0) i_time_val = 4'($urandom);
      if ($urandom_range(0, 39) == 0) i_en = ~i_en;
      i_timeout = $urandom_range(0, 299) == 0;
      i_start_timer = $urandom_range(0, 999) == 0;
    end
    @(negedge clk);
    rst = 0; i_timeout = 0; i_start_timer = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
